// File: rtl/mem_bus_arbiter_pkg.sv
// ------------------------------------------------------------------
// mem_bus_arbiter_pkg: state encoding and helpers for mem_bus_arbiter
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE   = 3'd0,
    ARB_D_BUSY = 3'd1,
    ARB_D_HOLD = 3'd2,
    ARB_I_BUSY = 3'd3,
    ARB_I_HOLD = 3'd4,
    ARB_I_DROP = 3'd5
  } arb_state_e;

  // States in which a transaction is outstanding on the external bus.
  function automatic logic arb_owns_bus(input arb_state_e s);
    return (s == ARB_D_BUSY) || (s == ARB_I_BUSY) || (s == ARB_I_DROP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ------------------------------------------------------------------
// mem_bus_arbiter: single-port IF/MEM bus arbiter, data-first priority
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inst_ce_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_data_o,
  input  logic                mem_ce_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_data_i,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic                stall_if_i,
  input  logic                stall_mem_i,
  input  logic                flush_i,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e          state_q, state_d;
  logic                bus_req_q, bus_req_d;
  logic                bus_we_q, bus_we_d;
  logic [SEL_W-1:0]    bus_sel_q, bus_sel_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0]   dbuf_q, dbuf_d;
  logic [DATA_W-1:0]   ibuf_q, ibuf_d;

  always_comb begin
    state_d     = state_q;
    bus_we_d    = bus_we_q;
    bus_sel_d   = bus_sel_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    dbuf_d      = dbuf_q;
    ibuf_d      = ibuf_q;

    case (state_q)
      ARB_IDLE: begin
        if (mem_ce_i) begin
          state_d     = ARB_D_BUSY;
          bus_we_d    = mem_we_i;
          bus_sel_d   = mem_sel_i;
          bus_addr_d  = mem_addr_i;
          bus_wdata_d = mem_data_i;
        end else if (inst_ce_i && !flush_i) begin
          state_d    = ARB_I_BUSY;
          bus_we_d   = 1'b0;
          bus_sel_d  = '1;
          bus_addr_d = inst_addr_i;
        end
      end
      ARB_D_BUSY: begin
        if (bus_ack_i) begin
          state_d = ARB_D_HOLD;
          dbuf_d  = bus_rdata_i;
        end
      end
      ARB_D_HOLD: begin
        if (!stall_mem_i) state_d = ARB_IDLE;
      end
      ARB_I_BUSY: begin
        // A flush in the ack cycle still discards the fetched word.
        if (bus_ack_i) begin
          if (flush_i) begin
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_I_HOLD;
            ibuf_d  = bus_rdata_i;
          end
        end else if (flush_i) begin
          state_d = ARB_I_DROP;
        end
      end
      ARB_I_DROP: begin
        if (bus_ack_i) state_d = ARB_IDLE;
      end
      ARB_I_HOLD: begin
        if (!stall_if_i || flush_i) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase

    bus_req_d = arb_owns_bus(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      dbuf_q      <= '0;
      ibuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_sel_q   <= bus_sel_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      dbuf_q      <= dbuf_d;
      ibuf_q      <= ibuf_d;
    end
  end

  // Stall requests are combinational so a fresh request stalls in its first cycle.
  assign stallreq_mem_o = rst_n & mem_ce_i & (state_q != ARB_D_HOLD);
  assign stallreq_if_o  = rst_n & inst_ce_i & ~flush_i & (state_q != ARB_I_HOLD);

  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_wdata_o = bus_wdata_q;
  assign mem_data_o  = dbuf_q;
  assign inst_data_o = ibuf_q;

endmodule

`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Single-port memory arbiter between the IF stage (instruction fetch) and the MEM stage (loads/stores, LL/SC) of the five-stage pipeline. It is a sequential block on one shared external memory bus with a request/acknowledge handshake. It grants the data port over the instruction port and issues stall requests to the pipeline control unit until each access completes. Read results are held in per-port buffers while the pipeline stays stalled.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; `sel` width is DATA_W/8

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low (`RstEnable` = 0)
- inst_ce_i  in  1  IF fetch request
- inst_addr_i  in  ADDR_W  fetch address
- inst_data_o  out  DATA_W  fetched word
- mem_ce_i  in  1  MEM access request
- mem_we_i  in  1  1 = store
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  ADDR_W  data address
- mem_data_i  in  DATA_W  store data
- mem_data_o  out  DATA_W  load data
- stall_if_i  in  1  ctrl is holding the IF stage
- stall_mem_i  in  1  ctrl is holding the MEM stage
- flush_i  in  1  pipeline flush (exception or redirect)
- stallreq_if_o  out  1  IF stall request
- stallreq_mem_o  out  1  MEM stall request
- bus_req_o, bus_we_o  out  1  bus request, bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  ADDR_W  bus address
- bus_wdata_o  out  DATA_W  bus write data
- bus_ack_i  in  1  one-cycle completion strobe
- bus_rdata_i  in  DATA_W  read data, valid in the ack cycle

## Operation
- FSM states:
  - IDLE: no transaction in flight.
  - D_BUSY: data transaction in flight.
  - D_HOLD: data result buffered.
  - I_BUSY: instruction fetch in flight.
  - I_HOLD: fetch result buffered.
  - I_DROP: fetch in flight whose result will be discarded.
- Transitions out of IDLE:
  - mem_ce_i=1 → D_BUSY. Latch addr, we, sel and wdata into the bus registers.
  - Otherwise, inst_ce_i=1 and flush_i=0 → I_BUSY. Latch inst_addr_i; bus_we_o=0, bus_sel_o=4'b1111.
  - Data has fixed priority over instruction.
- D_BUSY:
  - On bus_ack_i, capture bus_rdata_i into dbuf and go to D_HOLD. Stores capture as well; the value is ignored.
  - flush_i does not affect D_BUSY.
- D_HOLD:
  - Go to IDLE when stall_mem_i=0; the access has been consumed.
  - Otherwise remain in D_HOLD.
- I_BUSY:
  - On ack with flush_i=0, capture into ibuf and go to I_HOLD.
  - On ack with flush_i=1, go to IDLE.
  - flush_i=1 without ack → I_DROP.
- I_DROP: go to IDLE on ack and discard the data.
- I_HOLD:
  - Go to IDLE when stall_if_i=0 or flush_i=1.
- stallreq_mem_o = mem_ce_i & (state≠D_HOLD). This is combinational, so a new data request stalls in its first cycle.
- stallreq_if_o = inst_ce_i & (state≠I_HOLD), and is forced to 0 when flush_i=1.
- mem_data_o = dbuf and inst_data_o = ibuf. Both hold their value between accesses.
- A transaction in flight is never aborted. bus_addr_o, bus_we_o, bus_sel_o and bus_wdata_o stay stable from request until ack.
- A data request arriving during I_BUSY or I_HOLD waits until the FSM returns to IDLE.

## Timing
- Reset: all registers clear asynchronously.
  - state=IDLE.
  - bus_req_o, bus_we_o = 0; bus_sel_o = 0; bus_addr_o, bus_wdata_o, dbuf, ibuf = 0.
  - The stallreq outputs are 0 while rst_n=0.
  - Reset mid-transaction drops bus_req_o immediately; a later bus_ack_i is ignored because the FSM is in IDLE.
- bus_req_o is registered: 1 in every BUSY/DROP state, 0 otherwise.
- Latency, zero-wait bus (ack in first request cycle):
  - Request at cycle 0 → bus_req_o=1 in cycle 1 → buffer valid and stallreq low in cycle 2.
  - Minimum stall is 2 cycles; each bus wait state adds 1.
- bus_ack_i outside a BUSY/DROP state is ignored.
- Ack and flush arriving in the same I_BUSY cycle: flush wins and the FSM goes to IDLE.
- Simultaneous inst and data requests: data is served first, then inst. Back-to-back: D_HOLD → IDLE → I_BUSY, with no same-cycle regrant.

## Structure
- State encodings (3-bit) belong in macro.v as `ARB_IDLE` … `ARB_I_DROP`, alongside the existing `ChipEnable`/`WriteEnable`/`ZeroWord` macros. These are reused by the top level and the bench.
- Single module containing the FSM plus two DATA_W buffers; no sub-module is warranted.

## Test plan
- Zero-wait load: mem_ce_i=1, we=0, addr=0x100, ack in the first request cycle with rdata=0xDEADBEEF, stall_mem_i deasserted at cycle 2 → stallreq_mem_o high in cycles 0–1, mem_data_o=0xDEADBEEF from cycle 2, state IDLE at cycle 3.
- Store with 3 wait states: sel=4'b0011, addr=0x204, wdata=0x0000BEEF → bus_we_o=1 and the bus fields stay stable for 4 cycles, stallreq_mem_o low after ack+1.
- Simultaneous requests: inst 0x0, data 0x80 → the data transaction is issued first. stallreq_if_o stays high until the fetch completes, and the fetch bus_addr_o=0x0 appears after D_HOLD.
- Flush during fetch: flush_i pulse in I_BUSY, ack two cycles later with 0x12345678 → ibuf unchanged, FSM in IDLE, a new fetch is then issued.
- Hold under external stall: load completes while stall_mem_i=1 for 3 cycles → mem_data_o stable, no new bus_req_o, stallreq_mem_o=0.
- Async reset asserted in D_BUSY → bus_req_o=0 without a clock edge; a late ack is ignored after release.
